dds_ftw_write_sequencer: RTL and testbench
==========================================

Name: dds_ftw_write_sequencer

Overview:
- Sequences frequency-tuning-word (FTW) writes from the Rabbit-side serial reader into the DDS serial port.
- Buffers 32-bit FTWs delivered by the reader in a small FIFO.
- On each trigger edge, pops one FTW, shifts instruction byte plus FTW MSB-first over DDS SCLK/SDIO/CS_N, then pulses IO_UPDATE.
- Sits between the reader and the DDS pins; one FTW per trigger gives deterministic frequency stepping.

Parameters:
- CLK_DIV, 2: system clocks per SCLK half-period (>=1).
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW = 8.
- INSTR_BYTE, 8'h04: DDS write instruction (FTW0 register address, write bit = 0).
- IOUP_CYCLES, 4: IO_UPDATE pulse width in clocks (>=1).

Ports:
- fifty_MHz_int  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- ftw_in  in  32  FTW from reader
- ftw_valid  in  1  one-cycle push strobe
- trigger_in  in  1  asynchronous trigger; rising edge starts one write
- dds_sclk  out  1  DDS serial clock, idles low
- dds_sdio  out  1  DDS serial data, MSB first
- dds_cs_n  out  1  DDS chip select, active low
- dds_io_update  out  1  DDS IO_UPDATE pulse
- busy  out  1  high whenever state != IDLE
- fifo_count  out  FIFO_AW+1  words buffered
- overflow  out  1  one-cycle pulse: push dropped, FIFO full
- trig_miss  out  1  one-cycle pulse: trigger ignored

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: dds_sclk=0, dds_sdio=0, dds_cs_n=1, dds_io_update=0, busy=0, fifo_count=0, overflow=0, trig_miss=0. Reset mid-transfer aborts immediately, releases CS_N, and empties the FIFO.
- Trigger path: trigger_in passes a 2-FF synchronizer, then a rising-edge detector. The first clock trigger_in is sampled high (after low) is cycle n; the edge pulse occurs at n+2.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, IOUP.
- IDLE: on edge pulse with fifo_count>0, pop the head into a 40-bit shift register {INSTR_BYTE, ftw} and enter CS_SETUP at n+3, with dds_cs_n=0 and dds_sdio=bit39. If fifo_count==0, pulse trig_miss and stay in IDLE.
- CS_SETUP: hold CLK_DIV clocks, then enter SHIFT.
- SHIFT:
  - dds_sclk toggles every CLK_DIV clocks, giving 40 rising edges. The DDS samples on the rising edge.
  - dds_sdio advances one bit on each falling edge, except the final falling edge.
  - After the 40th falling edge (80*CLK_DIV clocks), go to CS_HOLD with sclk=0.
- CS_HOLD: hold CLK_DIV clocks, then dds_cs_n=1 and enter IOUP.
- IOUP: dds_io_update=1 for exactly IOUP_CYCLES, then return to IDLE.
- Total busy length = (82*CLK_DIV)+IOUP_CYCLES clocks; 168 at defaults.
- Trigger edge while busy: not queued; pulse trig_miss.
- FIFO push:
  - When ftw_valid && fifo_count==2**FIFO_AW, the data is dropped and overflow pulses.
  - Simultaneous push and pop: both happen, count unchanged, and push is accepted even when full.
  - A push in the same cycle as the edge pulse with an empty FIFO does not satisfy that trigger (count is registered), so trig_miss pulses.
- Pointers wrap modulo depth. fifo_count updates the cycle after the push/pop.

Optional Feature:
- Macro: DDS_SEQ_MISS_CNT_EN.
- Defined: adds output miss_count[15:0]. It increments on every trig_miss pulse, saturates at 16'hFFFF, and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package dds_seq_pkg holds:
  - the FSM state enum;
  - FTW_W=32, INSTR_W=8, SHIFT_W=40;
  - the default INSTR_BYTE constant.
- Sub-module ftw_fifo: synchronous FIFO, width 32, depth 2**FIFO_AW, with push/pop/count/full/empty. It is reusable for other DDS register streams.

Test Plan:
- Push 32'h12345678, raise trigger_in at cycle n: cs_n low at n+3; 40 SCLK rising edges with sampled bits 0x04_12345678 MSB first; io_update high 4 clocks; busy low after 168 clocks.
- Trigger with FIFO empty: trig_miss single pulse; no cs_n/sclk activity; busy stays 0.
- Push 9 words back-to-back (defaults): fifo_count=8 and one overflow pulse on the 9th. Then 8 triggers emit words 1..8 in order.
- Second trigger edge 50 clocks into a transfer: trig_miss pulses; the current transfer completes unchanged; FIFO count decrements by only 1.
- Assert reset during SHIFT (bit 20): cs_n=1, sclk=0, io_update=0 within the reset cycle (asynchronous); fifo_count=0 after release; the next trigger gives trig_miss.
- With DDS_SEQ_MISS_CNT_EN defined and miss_count forced near saturation: 3 misses give 16'hFFFD→FFFE→FFFF, and a 4th holds at 16'hFFFF.

Source files
------------

// File: rtl/dds_ftw_write_sequencer_pkg.sv
// dds_seq_pkg: shared widths, default instruction and FSM state type
// for the DDS FTW write sequencer.
package dds_seq_pkg;

   localparam int FTW_W   = 32;
   localparam int INSTR_W = 8;
   localparam int SHIFT_W = INSTR_W + FTW_W;

   localparam logic [INSTR_W-1:0] DEF_INSTR_BYTE = 8'h04;

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT,
      CS_HOLD,
      IOUP
   } seq_state_t;

endpackage

// File: rtl/dds_ftw_write_sequencer_ftw_fifo.sv
// ftw_fifo: synchronous FIFO for DDS register words; a push while full
// is accepted only when a pop happens in the same cycle.
module ftw_fifo #(
   parameter int W  = 32,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam int DEPTH = 2**AW;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/dds_ftw_write_sequencer.sv
// dds_ftw_write_sequencer: one buffered FTW is shifted to the DDS per trigger.
// DDS_SEQ_MISS_CNT_EN adds a saturating miss_count output.
module dds_ftw_write_sequencer
   import dds_seq_pkg::*;
#(
   parameter int                  CLK_DIV     = 2,
   parameter int                  FIFO_AW     = 3,
   parameter logic [INSTR_W-1:0]  INSTR_BYTE  = DEF_INSTR_BYTE,
   parameter int                  IOUP_CYCLES = 4
) (
   input  logic               fifty_MHz_int,
   input  logic               reset,
   input  logic [FTW_W-1:0]   ftw_in,
   input  logic               ftw_valid,
   input  logic               trigger_in,
   output logic               dds_sclk,
   output logic               dds_sdio,
   output logic               dds_cs_n,
   output logic               dds_io_update,
   output logic               busy,
   output logic [FIFO_AW:0]   fifo_count,
   output logic               overflow,
`ifdef DDS_SEQ_MISS_CNT_EN
   output logic [15:0]        miss_count,
`endif
   output logic               trig_miss
);

   localparam int CW = 16;
   localparam logic [CW-1:0] DIV_END  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] IOUP_END = CW'(IOUP_CYCLES - 1);

   seq_state_t         state, state_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [5:0]         bit_cnt, bit_cnt_n;
   logic [SHIFT_W-1:0] shreg, shreg_n;
   logic               sclk_n, cs_n_n, ioup_n, miss_n;
   logic               trig_s1, trig_s2, trig_s3, trig_edge;
   logic               pop;
   logic [FTW_W-1:0]   head;
   logic               fifo_full, fifo_empty;

   ftw_fifo #(
      .W  (FTW_W),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk   (fifty_MHz_int),
      .rst   (reset),
      .push  (ftw_valid),
      .pop   (pop),
      .din   (ftw_in),
      .dout  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign busy     = (state != IDLE);
   assign dds_sdio = shreg[SHIFT_W-1];

   // Two-flop synchronizer, then a registered rising-edge pulse.
   always_ff @(posedge fifty_MHz_int or posedge reset) begin
      if (reset) begin
         trig_s1   <= 1'b0;
         trig_s2   <= 1'b0;
         trig_s3   <= 1'b0;
         trig_edge <= 1'b0;
      end else begin
         trig_s1   <= trigger_in;
         trig_s2   <= trig_s1;
         trig_s3   <= trig_s2;
         trig_edge <= trig_s2 & ~trig_s3;
      end
   end

   always_ff @(posedge fifty_MHz_int or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         dds_sclk      <= 1'b0;
         dds_cs_n      <= 1'b1;
         dds_io_update <= 1'b0;
         trig_miss     <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         bit_cnt       <= bit_cnt_n;
         shreg         <= shreg_n;
         dds_sclk      <= sclk_n;
         dds_cs_n      <= cs_n_n;
         dds_io_update <= ioup_n;
         trig_miss     <= miss_n;
         overflow      <= ftw_valid && fifo_full && !pop;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      sclk_n    = dds_sclk;
      cs_n_n    = dds_cs_n;
      ioup_n    = dds_io_update;
      miss_n    = 1'b0;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            if (trig_edge) begin
               if (fifo_empty) begin
                  miss_n = 1'b1;
               end else begin
                  pop       = 1'b1;
                  shreg_n   = {INSTR_BYTE, head};
                  cs_n_n    = 1'b0;
                  cnt_n     = '0;
                  bit_cnt_n = '0;
                  state_n   = CS_SETUP;
               end
            end
         end
         CS_SETUP: begin
            if (cnt == DIV_END) begin
               cnt_n   = '0;
               state_n = SHIFT;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         SHIFT: begin
            if (cnt == DIV_END) begin
               cnt_n = '0;
               if (!dds_sclk) begin
                  sclk_n = 1'b1;
               end else begin
                  sclk_n = 1'b0;
                  // Last falling edge ends the frame without shifting.
                  if (bit_cnt == 6'd39) begin
                     state_n = CS_HOLD;
                  end else begin
                     shreg_n   = {shreg[SHIFT_W-2:0], 1'b0};
                     bit_cnt_n = bit_cnt + 1'b1;
                  end
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         CS_HOLD: begin
            if (cnt == DIV_END) begin
               cnt_n   = '0;
               cs_n_n  = 1'b1;
               ioup_n  = 1'b1;
               shreg_n = '0;
               state_n = IOUP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         IOUP: begin
            if (cnt == IOUP_END) begin
               cnt_n   = '0;
               ioup_n  = 1'b0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      if (trig_edge && state != IDLE) miss_n = 1'b1;
   end

`ifdef DDS_SEQ_MISS_CNT_EN
   always_ff @(posedge fifty_MHz_int or posedge reset) begin
      if (reset) begin
         miss_count <= '0;
      end else if (trig_miss && miss_count != 16'hFFFF) begin
         miss_count <= miss_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dds_ftw_write_sequencer.sv
// tb_dds_ftw_write_sequencer: directed stimulus with a frame scoreboard;
// the negedge monitor decodes each CS_N frame and checks it in order.
module tb_dds_ftw_write_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ftw_in = '0;
   logic        ftw_valid = 1'b0;
   logic        trigger_in = 1'b0;
   logic        dds_sclk, dds_sdio, dds_cs_n, dds_io_update;
   logic        dds_busy, overflow, trig_miss;
   logic [3:0]  fifo_count;
`ifdef DDS_SEQ_MISS_CNT_EN
   logic [15:0] miss_count;
`endif

   dds_ftw_write_sequencer dut (
      .fifty_MHz_int (clk),
      .reset         (reset),
      .ftw_in        (ftw_in),
      .ftw_valid     (ftw_valid),
      .trigger_in    (trigger_in),
      .dds_sclk      (dds_sclk),
      .dds_sdio      (dds_sdio),
      .dds_cs_n      (dds_cs_n),
      .dds_io_update (dds_io_update),
      .busy          (dds_busy),
      .fifo_count    (fifo_count),
      .overflow      (overflow),
`ifdef DDS_SEQ_MISS_CNT_EN
      .miss_count    (miss_count),
`endif
      .trig_miss     (trig_miss)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [39:0] frame;
      int          start;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   obs_miss = 0;
   int   exp_miss = 0;
   int   obs_ovf = 0;
   int   frames = 0;
   int   sclk_idle_err = 0;
   int   mon_bits = 0;
   int   busy_run = 0;
   int   iou_run = 0;
   int   start_cyc = 0;
   logic [39:0] sh = '0;
   logic p_sclk = 0, p_cs = 1, p_busy = 0, p_iou = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         mon_bits = 0;
         busy_run = 0;
         iou_run  = 0;
         p_sclk   = 0;
         p_cs     = 1;
         p_busy   = 0;
         p_iou    = 0;
      end else begin
         if (dds_cs_n && dds_sclk) sclk_idle_err++;
         if (!dds_cs_n && p_cs) begin
            mon_bits  = 0;
            sh        = '0;
            start_cyc = cyc;
         end
         if (!dds_cs_n && dds_sclk && !p_sclk) begin
            sh = {sh[38:0], dds_sdio};
            mon_bits++;
         end
         if (dds_cs_n && !p_cs) begin
            frames++;
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", 64'(frames), 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("frame_bits", 64'(sh), 64'(mon_e.frame));
               chk("frame_len", 64'(mon_bits), 64'd40);
               chk("cs_latency", 64'(start_cyc), 64'(mon_e.start));
            end
         end
         if (dds_busy) busy_run++;
         else if (p_busy) begin
            chk("busy_len", 64'(busy_run), 64'd168);
            busy_run = 0;
         end
         if (dds_io_update) iou_run++;
         else if (p_iou) begin
            chk("ioup_len", 64'(iou_run), 64'd4);
            iou_run = 0;
         end
         if (trig_miss) obs_miss++;
         if (overflow) obs_ovf++;
         p_sclk = dds_sclk;
         p_cs   = dds_cs_n;
         p_busy = dds_busy;
         p_iou  = dds_io_update;
      end
   end

   task automatic push(input logic [31:0] w);
      ftw_in    = w;
      ftw_valid = 1'b1;
      @(negedge clk);
      ftw_valid = 1'b0;
   endtask

   task automatic trig(input bit hit, input logic [31:0] w);
      if (hit) exp_q.push_back('{frame: {8'h04, w}, start: cyc + 4});
      else exp_miss++;
      trigger_in = 1'b1;
      repeat (4) @(negedge clk);
      trigger_in = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (dds_busy && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("idle_timeout", 64'(t >= 400), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int t;
      int f0;
      repeat (3) @(negedge clk);
      chk("rst_cs_n", 64'(dds_cs_n), 64'd1);
      chk("rst_sclk", 64'(dds_sclk), 64'd0);
      chk("rst_sdio", 64'(dds_sdio), 64'd0);
      chk("rst_ioup", 64'(dds_io_update), 64'd0);
      chk("rst_busy", 64'(dds_busy), 64'd0);
      chk("rst_count", 64'(fifo_count), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_miss", 64'(trig_miss), 64'd0);
`ifdef DDS_SEQ_MISS_CNT_EN
      chk("rst_miss_cnt", 64'(miss_count), 64'd0);
`endif
      reset = 1'b0;
      repeat (2) @(negedge clk);

      push(32'h12345678);
      chk("count_one", 64'(fifo_count), 64'd1);
      trig(1'b1, 32'h12345678);
      wait_idle();
      chk("count_drain", 64'(fifo_count), 64'd0);

      f0 = frames;
      trig(1'b0, '0);
      chk("empty_miss", 64'(obs_miss), 64'(exp_miss));
      chk("empty_busy", 64'(dds_busy), 64'd0);
      chk("empty_noframe", 64'(frames), 64'(f0));

      for (int i = 1; i <= 9; i++) begin
         ftw_in    = 32'(i);
         ftw_valid = 1'b1;
         @(negedge clk);
      end
      ftw_valid = 1'b0;
      @(negedge clk);
      chk("full_count", 64'(fifo_count), 64'd8);
      chk("ovf_pulses", 64'(obs_ovf), 64'd1);
      for (int i = 1; i <= 8; i++) begin
         trig(1'b1, 32'(i));
         wait_idle();
      end
      chk("count_after8", 64'(fifo_count), 64'd0);

      push(32'hA5A50F0F);
      push(32'hDEADBEEF);
      trig(1'b1, 32'hA5A50F0F);
      repeat (47) @(negedge clk);
      exp_miss++;
      trigger_in = 1'b1;
      repeat (4) @(negedge clk);
      trigger_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_miss", 64'(obs_miss), 64'(exp_miss));
      chk("busy_count", 64'(fifo_count), 64'd1);
      wait_idle();
      chk("after_busy_count", 64'(fifo_count), 64'd1);
      trig(1'b1, 32'hDEADBEEF);
      wait_idle();

      push(32'hCAFEF00D);
      push(32'h0BADCAFE);
      trig(1'b1, 32'hCAFEF00D);
      t = 0;
      while (mon_bits < 20 && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("bit20_timeout", 64'(t >= 300), 64'd0);
      #3 reset = 1'b1;
      #1;
      chk("abort_cs_n", 64'(dds_cs_n), 64'd1);
      chk("abort_sclk", 64'(dds_sclk), 64'd0);
      chk("abort_ioup", 64'(dds_io_update), 64'd0);
      chk("abort_busy", 64'(dds_busy), 64'd0);
      void'(exp_q.pop_back());
      @(negedge clk);
      #5 reset = 1'b0;
      @(negedge clk);
      chk("abort_count", 64'(fifo_count), 64'd0);
      trig(1'b0, '0);
      chk("abort_miss", 64'(obs_miss), 64'(exp_miss));

`ifdef DDS_SEQ_MISS_CNT_EN
      force dut.miss_count = 16'hFFFC;
      @(negedge clk);
      release dut.miss_count;
      trig(1'b0, '0);
      chk("mc_fffd", 64'(miss_count), 64'hFFFD);
      trig(1'b0, '0);
      chk("mc_fffe", 64'(miss_count), 64'hFFFE);
      trig(1'b0, '0);
      chk("mc_ffff", 64'(miss_count), 64'hFFFF);
      trig(1'b0, '0);
      chk("mc_sat", 64'(miss_count), 64'hFFFF);
`endif

      repeat (3) @(negedge clk);
      chk("frames_left", 64'(exp_q.size()), 64'd0);
      chk("miss_total", 64'(obs_miss), 64'(exp_miss));
      chk("ovf_total", 64'(obs_ovf), 64'd1);
      chk("sclk_idle", 64'(sclk_idle_err), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
